// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC capture scheduler: cycle-type codes, record
// layout and serializer state encoding.
package lpc_pkg;

  localparam logic [3:0] IO_READ  = 4'b0000;
  localparam logic [3:0] IO_WRITE = 4'b0010;

  // Record layout: {sync_timeout, cyctype_dir, addr[15:0], data}
  localparam int REC_W        = 29;
  localparam int REC_DATA_LSB = 0;
  localparam int REC_ADDR_LSB = 8;
  localparam int REC_TYPE_LSB = 24;
  localparam int REC_TMO_BIT  = 28;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_TYPE = 3'd2,
    ST_AHI  = 3'd3,
    ST_ALO  = 3'd4,
    ST_DATA = 3'd5
  } ser_state_e;

  function automatic logic [REC_W-1:0] pack_record(
    input logic        tmo,
    input logic [3:0]  cyctype_dir,
    input logic [15:0] addr,
    input logic [7:0]  data
  );
    return {tmo, cyctype_dir, addr, data};
  endfunction

endpackage

// File: rtl/lpc_rec_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot on the same edge.
module lpc_rec_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only slots behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lpc_capture_scheduler.sv
// Captures completed LPC cycles on the rising edge of the decoder's completion
// level, optionally filters by I/O address, and streams 5-byte frames out.
module lpc_capture_scheduler
  import lpc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter bit          FILTER_EN = 1'b0,
  parameter logic [15:0] ADDR_MIN  = 16'h0080,
  parameter logic [15:0] ADDR_MAX  = 16'h0080,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                   lpc_clock,
  input  logic                   reset,
  input  logic [3:0]             in_cyctype_dir,
  input  logic [31:0]            in_addr,
  input  logic [7:0]             in_data,
  input  logic                   in_sync_timeout,
  input  logic                   in_clock_enable,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_count,
  output logic                   busy
);

  ser_state_e       state_q, state_d;
  logic [REC_W-1:0] shreg_q, shreg_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       drop_q, drop_d;
  logic             prev_ce_q, prev_ce_d;

  logic             capture, in_window, accept, pop;
  logic             fifo_full, fifo_empty;
  logic [REC_W-1:0] fifo_head;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^in_addr[31:16];

  assign capture   = in_clock_enable & ~prev_ce_q;
  assign in_window = (in_addr[15:0] >= ADDR_MIN) && (in_addr[15:0] <= ADDR_MAX);
  assign accept    = capture & (~FILTER_EN | in_window);

  lpc_rec_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (lpc_clock),
    .reset     (reset),
    .push      (accept),
    .push_data (pack_record(in_sync_timeout, in_cyctype_dir, in_addr[15:0], in_data)),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Each state's byte is loaded on the handshake that enters it, so out_byte
  // is a plain register and holds still under backpressure.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    prev_ce_d   = in_clock_enable;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shreg_d     = fifo_head;
          state_d     = ST_SYNC;
          out_valid_d = 1'b1;
          out_byte_d  = SYNC_BYTE;
        end
      end
      ST_SYNC: if (out_ready) begin
        state_d    = ST_TYPE;
        out_byte_d = {shreg_q[REC_TMO_BIT], 3'b000, shreg_q[REC_TYPE_LSB +: 4]};
      end
      ST_TYPE: if (out_ready) begin
        state_d    = ST_AHI;
        out_byte_d = shreg_q[REC_ADDR_LSB + 8 +: 8];
      end
      ST_AHI: if (out_ready) begin
        state_d    = ST_ALO;
        out_byte_d = shreg_q[REC_ADDR_LSB +: 8];
      end
      ST_ALO: if (out_ready) begin
        state_d    = ST_DATA;
        out_byte_d = shreg_q[REC_DATA_LSB +: 8];
      end
      ST_DATA: if (out_ready) begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = fifo_head;
          state_d    = ST_SYNC;
          out_byte_d = SYNC_BYTE;
        end else begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_byte_d  = 8'h00;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_byte_d  = 8'h00;
      end
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && fifo_full && !pop && drop_q != 8'hFF) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      out_byte_q  <= 8'h00;
      out_valid_q <= 1'b0;
      drop_q      <= 8'h00;
      prev_ce_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      prev_ce_q   <= prev_ce_d;
    end
  end

  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_lpc_capture_scheduler.sv
// Directed bench for lpc_capture_scheduler: an unfiltered instance plus a
// filtered instance (window 0x80-0x80) share the capture inputs.
module tb_lpc_capture_scheduler;
  import lpc_pkg::*;

  logic        lpc_clock;
  logic        reset;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [7:0]  in_data;
  logic        in_sync_timeout;
  logic        in_clock_enable;
  logic        out_ready;

  logic [7:0]  out_byte, out_byte_f;
  logic        out_valid, out_valid_f;
  logic [2:0]  fifo_count, fifo_count_f;
  logic [7:0]  drop_count, drop_count_f;
  logic        busy, busy_f;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_main [$];
  logic [7:0] q_filt [$];
  logic [7:0] expq [$];

  lpc_capture_scheduler #(.DEPTH(4)) dut (
    .lpc_clock       (lpc_clock),
    .reset           (reset),
    .in_cyctype_dir  (in_cyctype_dir),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_sync_timeout (in_sync_timeout),
    .in_clock_enable (in_clock_enable),
    .out_byte        (out_byte),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fifo_count      (fifo_count),
    .drop_count      (drop_count),
    .busy            (busy)
  );

  lpc_capture_scheduler #(.DEPTH(4), .FILTER_EN(1'b1), .ADDR_MIN(16'h0080), .ADDR_MAX(16'h0080)) dut_f (
    .lpc_clock       (lpc_clock),
    .reset           (reset),
    .in_cyctype_dir  (in_cyctype_dir),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_sync_timeout (in_sync_timeout),
    .in_clock_enable (in_clock_enable),
    .out_byte        (out_byte_f),
    .out_valid       (out_valid_f),
    .out_ready       (1'b1),
    .fifo_count      (fifo_count_f),
    .drop_count      (drop_count_f),
    .busy            (busy_f)
  );

  initial lpc_clock = 1'b0;
  always #5 lpc_clock = ~lpc_clock;

  // Inputs change just after the rising edge, so the falling edge sees the
  // valid/ready pair that will handshake on the next rising edge.
  always @(negedge lpc_clock) begin
    if (!reset) begin
      if (out_valid && out_ready) q_main.push_back(out_byte);
      if (out_valid_f) q_filt.push_back(out_byte_f);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge lpc_clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Raise the completion level for one cycle, then scramble the inputs so any
  // sampling outside the capture cycle would show up in the frame.
  task automatic applyStimulus(input logic [3:0] ct, input logic [15:0] a,
                               input logic [7:0] d, input logic tmo);
    in_cyctype_dir  = ct;
    in_addr         = {16'hBEEF, a};
    in_data         = d;
    in_sync_timeout = tmo;
    in_clock_enable = 1'b1;
    tick(1);
    in_clock_enable = 1'b0;
    in_cyctype_dir  = 4'hF;
    in_addr         = 32'hDEAD_5A5A;
    in_data         = 8'hEE;
    in_sync_timeout = 1'b1;
    tick(1);
  endtask

  task automatic addFrame(input logic [3:0] ct, input logic [15:0] a,
                          input logic [7:0] d, input logic tmo);
    expq.push_back(8'hA5);
    expq.push_back({tmo, 3'b000, ct});
    expq.push_back(a[15:8]);
    expq.push_back(a[7:0]);
    expq.push_back(d);
  endtask

  task automatic compareQueue(input string tag, input logic [7:0] got [$]);
    checkOutput({tag, "_len"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      checkOutput($sformatf("%s_b%0d", tag, i),
                  (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, expq[i]});
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while ((busy || busy_f) && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_idle_timeout"}, busy || busy_f, 1'b0);
  endtask

  task automatic resetDut();
    reset           = 1'b1;
    in_clock_enable = 1'b0;
    tick(2);
    reset = 1'b0;
    q_main.delete();
    q_filt.delete();
    expq.delete();
    tick(1);
  endtask

  initial begin
    logic [7:0] t1_bytes [5];
    t1_bytes = '{8'hA5, 8'h00, 8'h00, 8'h80, 8'h3C};
    reset = 1'b1;
    in_cyctype_dir = 4'h0; in_addr = '0; in_data = '0;
    in_sync_timeout = 1'b0; in_clock_enable = 1'b0; out_ready = 1'b1;

    resetDut();
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_byte", out_byte, 8'h00);
    checkOutput("rst_count", fifo_count, 3'd0);
    checkOutput("rst_drop", drop_count, 8'd0);
    checkOutput("rst_busy", busy, 1'b0);

    // Single capture, cycle-exact latency and byte order.
    in_cyctype_dir = IO_READ; in_addr = 32'h0000_0080; in_data = 8'h3C; in_sync_timeout = 1'b0;
    in_clock_enable = 1'b1;
    tick(1);
    in_clock_enable = 1'b0;
    checkOutput("t1_count_after_capture", fifo_count, 3'd1);
    checkOutput("t1_valid_at_capture", out_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput($sformatf("t1_valid%0d", i), out_valid, 1'b1);
      checkOutput($sformatf("t1_byte%0d", i), out_byte, t1_bytes[i]);
    end
    tick(1);
    checkOutput("t1_valid_end", out_valid, 1'b0);
    checkOutput("t1_busy_end", busy, 1'b0);

    // Backpressure held for three cycles while AHI is on the bus.
    resetDut();
    applyStimulus(IO_READ, 16'h0080, 8'h3C, 1'b0);
    tick(2);
    checkOutput("t2_ahi_byte", out_byte, 8'h00);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput($sformatf("t2_hold_valid%0d", i), out_valid, 1'b1);
      checkOutput($sformatf("t2_hold_byte%0d", i), out_byte, 8'h00);
    end
    out_ready = 1'b1;
    tick(1);
    checkOutput("t2_alo_byte", out_byte, 8'h80);
    tick(1);
    checkOutput("t2_data_byte", out_byte, 8'h3C);
    waitIdle("t2", 20);

    // Overflow: six captures into a stalled stream.
    resetDut();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(IO_WRITE, 16'h0010 + 16'(i), 8'h40 + 8'(i), 1'b0);
      if (i <= 5) addFrame(IO_WRITE, 16'h0010 + 16'(i), 8'h40 + 8'(i), 1'b0);
    end
    checkOutput("t3_count_full", fifo_count, 3'd4);
    checkOutput("t3_drop", drop_count, 8'd1);
    checkOutput("t3_valid_pending", out_valid, 1'b1);
    checkOutput("t3_sync_pending", out_byte, 8'hA5);
    q_main.delete();
    out_ready = 1'b1;
    waitIdle("t3", 100);
    compareQueue("t3_stream", q_main);
    checkOutput("t3_count_end", fifo_count, 3'd0);
    checkOutput("t3_drop_end", drop_count, 8'd1);

    // Address window: only 0x0080 passes the filtered instance.
    resetDut();
    applyStimulus(IO_WRITE, 16'h0080, 8'h11, 1'b0);
    applyStimulus(IO_WRITE, 16'h0081, 8'h22, 1'b0);
    applyStimulus(IO_WRITE, 16'h007F, 8'h33, 1'b0);
    waitIdle("t4", 100);
    addFrame(IO_WRITE, 16'h0080, 8'h11, 1'b0);
    compareQueue("t4_filtered", q_filt);
    checkOutput("t4_drop_f", drop_count_f, 8'd0);
    checkOutput("t4_main_len", q_main.size(), 15);

    // Timeout flag with the completion level held high for ten cycles.
    resetDut();
    in_cyctype_dir = IO_WRITE; in_addr = 32'h0000_0080; in_data = 8'h5E; in_sync_timeout = 1'b1;
    in_clock_enable = 1'b1;
    tick(10);
    in_clock_enable = 1'b0;
    waitIdle("t5", 50);
    addFrame(IO_WRITE, 16'h0080, 8'h5E, 1'b1);
    compareQueue("t5_stream", q_main);
    checkOutput("t5_type_byte", q_main.size() > 1 ? q_main[1] : 8'h00, 8'h82);

    // Reset during ALO with a second record still buffered.
    resetDut();
    applyStimulus(IO_READ, 16'h1234, 8'h56, 1'b0);
    applyStimulus(IO_READ, 16'h0080, 8'h77, 1'b0);
    tick(1);
    checkOutput("t6_alo_byte", out_byte, 8'h34);
    checkOutput("t6_count_before", fifo_count, 3'd1);
    reset = 1'b1;
    tick(1);
    checkOutput("t6_valid_after_rst", out_valid, 1'b0);
    checkOutput("t6_count_after_rst", fifo_count, 3'd0);
    checkOutput("t6_drop_after_rst", drop_count, 8'd0);
    reset = 1'b0;
    q_main.delete();
    q_filt.delete();
    expq.delete();
    tick(1);
    applyStimulus(IO_WRITE, 16'h0300, 8'h9A, 1'b0);
    waitIdle("t6", 50);
    addFrame(IO_WRITE, 16'h0300, 8'h9A, 1'b0);
    compareQueue("t6_fresh", q_main);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpc_capture_scheduler.md
Name: lpc_capture_scheduler

Overview:
- Sits downstream of the LPC cycle decoder in the sniffer, in the lpc_clock domain.
- Captures each completed decoded cycle (cyctype/dir, address, data, sync-timeout flag), optionally filters it by an I/O address window, and buffers it in a small FIFO.
- Schedules buffered records out as 5-byte framed messages over a byte-wide valid/ready stream, which feeds the UART transmitter.

Parameters:
- DEPTH, 4, FIFO depth in records; power of two, minimum 2.
- FILTER_EN, 0, 1 = accept only addresses inside [ADDR_MIN, ADDR_MAX]; 0 = accept all.
- ADDR_MIN, 16'h0080, inclusive lower bound of the filter window, compared against in_addr[15:0].
- ADDR_MAX, 16'h0080, inclusive upper bound of the filter window.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- lpc_clock  in  1  block clock; all registers update on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_cyctype_dir  in  4  decoder cycle type/direction (LPC 1.1 encoding).
- in_addr  in  32  decoder address; only [15:0] is used.
- in_data  in  8  decoder data byte.
- in_sync_timeout  in  1  decoder sync-timeout flag.
- in_clock_enable  in  1  decoder completion level; rises when a cycle completes and stays high until the next START.
- out_byte  out  8  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  downstream ready.
- fifo_count  out  $clog2(DEPTH)+1  records currently buffered.
- drop_count  out  8  records dropped because the FIFO was full; saturates at 255.
- busy  out  1  high when state != IDLE or fifo_count != 0.

Behaviour:
- Reset (synchronous, high): state=IDLE; FIFO empty; fifo_count=0; drop_count=0; out_valid=0; out_byte=0; prev_ce=0; busy=0. Reset mid-frame abandons the frame; no partial frame resumes after reset.
- Capture:
  - capture = in_clock_enable & ~prev_ce; prev_ce <= in_clock_enable every cycle.
  - A level held high produces exactly one capture.
  - Record = {in_sync_timeout, in_cyctype_dir, in_addr[15:0], in_data}, 29 bits.
- Filter: accept = capture & (!FILTER_EN | (ADDR_MIN <= in_addr[15:0] <= ADDR_MAX)), unsigned compare.
- Write:
  - accept & !full: record written at the same clock edge.
  - accept & full & no pop that cycle: record dropped; drop_count += 1 unless it is already 255.
  - accept & full & pop that cycle: write succeeds; fifo_count unchanged.
- Serializer FSM states: IDLE, SYNC, TYPE, AHI, ALO, DATA.
  - IDLE: if FIFO not empty, pop the head into the shift register and go to SYNC.
  - Bytes by state:
    - SYNC = SYNC_BYTE.
    - TYPE = {sync_timeout, 3'b000, cyctype_dir}.
    - AHI = addr[15:8].
    - ALO = addr[7:0].
    - DATA = data.
  - out_valid=1 in every state except IDLE.
  - Advance only on out_valid & out_ready. out_byte is registered and held stable while out_valid & !out_ready.
  - DATA handshake: if FIFO not empty, pop and go to SYNC (back-to-back, no idle cycle); else go to IDLE with out_valid=0.
  - Popping happens only on the IDLE->SYNC transition or on the DATA handshake.
- Latency: capture at edge k with FIFO empty and state IDLE -> FIFO written at edge k -> pop at edge k+1 -> out_valid=1 after edge k+1. With out_ready held high, a frame takes 5 cycles.
- Ordering: strictly FIFO; frames never interleave.
- fifo_count updates at the edge of the write or pop; a simultaneous write and pop leaves it unchanged.
- in_* inputs are sampled only on the capture cycle; changes in other cycles are ignored.

Decomposition:
- Package lpc_pkg holds:
  - cyctype/dir constants (IO_READ=4'b0000, IO_WRITE=4'b0010).
  - REC_W=29 and record field offsets.
  - serializer state encoding (3-bit).
  - default SYNC_BYTE.
- One sub-module, lpc_rec_fifo: synchronous FIFO parameterised by width and DEPTH, with push, pop, full, empty, count and a registered head output.
- Capture, filter and serializer FSM live in the top module.

Test Plan:
- Single capture: in_clock_enable rises with cyctype 0000, addr 0x0080, data 0x3C, out_ready=1 -> out_valid high the cycle after capture; bytes A5, 00, 00, 80, 3C on 5 consecutive cycles; then out_valid=0, busy=0.
- Backpressure: same record, out_ready low for 3 cycles during AHI -> out_byte stays 0x00 with out_valid=1 throughout; ALO=0x80 follows once ready returns.
- Overflow: DEPTH=4, out_ready=0, 6 captures -> fifo_count=4; SYNC byte of record 1 is pending; drop_count=1; releasing out_ready yields records 1-5 in order; record 6 never appears.
- Filter: FILTER_EN=1, window 0x80-0x80; captures at 0x0080, 0x0081, 0x007F -> only the 0x0080 frame is emitted; drop_count=0.
- Timeout and level hold: in_sync_timeout=1, in_clock_enable held high 10 cycles -> exactly one frame, TYPE byte = 0x80 | cyctype.
- Reset mid-frame: assert reset during ALO -> next cycle out_valid=0, fifo_count=0, drop_count=0; a new capture then emits a complete fresh frame starting at A5.
